// File: rtl/adder_share_sched.sv
`default_nettype none
// ============================================================================
// Module      : adder_share_sched
// Description : Round-robin scheduler time-sharing one external 12-bit adder
//               among NUM_REQ requesters; results return tagged by requester.
// Revision    : 1.0  initial release
// ============================================================================
module adder_share_sched #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2,
    parameter int CNT_W   = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_REQ-1:0]    req_valid,
    input  logic [NUM_REQ*12-1:0] req_a,
    input  logic [NUM_REQ*12-1:0] req_b,
    output logic [NUM_REQ-1:0]    req_ready,
    output logic [23:0]           add_in,
    input  logic [12:0]           add_out,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [ID_W-1:0]       rsp_id,
    output logic [12:0]           rsp_sum,
    output logic [CNT_W-1:0]      op_count
);

    localparam logic [1:0]    C_IDLE    = 2'd0;
    localparam logic [1:0]    C_CALC    = 2'd1;
    localparam logic [1:0]    C_RESP    = 2'd2;
    localparam logic [ID_W:0] C_NUM_REQ = (ID_W+1)'(NUM_REQ);
    localparam logic [ID_W-1:0] C_LAST  = ID_W'(NUM_REQ - 1);

    logic [1:0]       r_state;
    logic [ID_W-1:0]  r_rr_ptr;
    logic [ID_W-1:0]  r_id_q;
    logic [23:0]      r_add_in;
    logic             r_rsp_valid;
    logic [ID_W-1:0]  r_rsp_id;
    logic [12:0]      r_rsp_sum;
    logic [CNT_W-1:0] r_op_count;

    logic             w_any;
    logic [ID_W-1:0]  w_gidx;
    logic             w_arb_en;
    logic             w_take;
    logic [11:0]      w_sel_a;
    logic [11:0]      w_sel_b;
    logic [23:0]      w_ileave;
    logic [ID_W-1:0]  w_next_ptr;

    // Scan requesters starting at the round-robin pointer, wrapping at NUM_REQ.
    always_comb begin : arb
        logic [ID_W:0] w_cand;
        w_any  = 1'b0;
        w_gidx = '0;
        w_cand = '0;
        for (int off = 0; off < NUM_REQ; off++) begin
            w_cand = {1'b0, r_rr_ptr} + (ID_W+1)'(off);
            if (w_cand >= C_NUM_REQ) begin
                w_cand = w_cand - C_NUM_REQ;
            end
            if (!w_any && req_valid[w_cand[ID_W-1:0]]) begin
                w_any  = 1'b1;
                w_gidx = w_cand[ID_W-1:0];
            end
        end
    end

    // A new operand pair may only be taken when no result is outstanding,
    // or when the outstanding result is handing off in this very cycle.
    assign w_arb_en = ~rst & ((r_state == C_IDLE) | ((r_state == C_RESP) & rsp_ready));
    assign w_take   = w_arb_en & w_any;

    always_comb begin
        req_ready = '0;
        if (w_take) begin
            req_ready[w_gidx] = 1'b1;
        end
    end

    assign w_sel_a    = req_a[int'(w_gidx)*12 +: 12];
    assign w_sel_b    = req_b[int'(w_gidx)*12 +: 12];
    assign w_next_ptr = (w_gidx == C_LAST) ? '0 : w_gidx + 1'b1;

    always_comb begin
        w_ileave = '0;
        for (int k = 0; k < 12; k++) begin
            w_ileave[2*k]   = w_sel_a[k];
            w_ileave[2*k+1] = w_sel_b[k];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= C_IDLE;
            r_rr_ptr    <= '0;
            r_id_q      <= '0;
            r_add_in    <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_id    <= '0;
            r_rsp_sum   <= '0;
            r_op_count  <= '0;
        end else begin
            case (r_state)
                C_IDLE: begin
                    if (w_take) begin
                        r_add_in <= w_ileave;
                        r_id_q   <= w_gidx;
                        r_rr_ptr <= w_next_ptr;
                        r_state  <= C_CALC;
                    end
                end
                C_CALC: begin
                    r_rsp_sum   <= add_out;
                    r_rsp_id    <= r_id_q;
                    r_rsp_valid <= 1'b1;
                    r_state     <= C_RESP;
                end
                C_RESP: begin
                    if (rsp_ready) begin
                        r_op_count  <= r_op_count + 1'b1;
                        r_rsp_valid <= 1'b0;
                        if (w_take) begin
                            r_add_in <= w_ileave;
                            r_id_q   <= w_gidx;
                            r_rr_ptr <= w_next_ptr;
                            r_state  <= C_CALC;
                        end else begin
                            r_state  <= C_IDLE;
                        end
                    end
                end
                default: begin
                    r_state <= C_IDLE;
                end
            endcase
        end
    end

    assign add_in    = r_add_in;
    assign rsp_valid = r_rsp_valid;
    assign rsp_id    = r_rsp_id;
    assign rsp_sum   = r_rsp_sum;
    assign op_count  = r_op_count;

endmodule
`default_nettype wire

// File: tb/tb_adder_share_sched.sv
`default_nettype none
// ============================================================================
// Module      : tb_adder_share_sched
// Description : Self-checking bench for adder_share_sched with a reference
//               adder, an abstract scheduling model and directed scenarios.
// Revision    : 1.0  initial release
// ============================================================================
module tb_adder_share_sched;

    localparam int NUM_REQ = 4;
    localparam int ID_W    = 2;
    localparam int CNT_W   = 16;

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic [NUM_REQ-1:0]    req_valid = '0;
    logic [NUM_REQ*12-1:0] req_a = '0;
    logic [NUM_REQ*12-1:0] req_b = '0;
    logic                  rsp_ready = 1'b0;

    logic [NUM_REQ-1:0] req_ready, req_ready4;
    logic [23:0]        add_in, add_in4;
    logic [12:0]        add_out, add_out4;
    logic               rsp_valid, rsp_valid4;
    logic [ID_W-1:0]    rsp_id, rsp_id4;
    logic [12:0]        rsp_sum, rsp_sum4;
    logic [CNT_W-1:0]   op_count;
    logic [3:0]         op_count4;

    int vectors    = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    function automatic logic [12:0] ref_adder(input logic [23:0] x);
        logic [11:0] a, b;
        for (int k = 0; k < 12; k++) begin
            a[k] = x[2*k];
            b[k] = x[2*k+1];
        end
        return {1'b0, a} + {1'b0, b};
    endfunction

    function automatic logic [23:0] ilv(input logic [11:0] a, input logic [11:0] b);
        logic [23:0] r;
        for (int k = 0; k < 12; k++) begin
            r[2*k]   = a[k];
            r[2*k+1] = b[k];
        end
        return r;
    endfunction

    function automatic logic [11:0] rnd12();
        int sel;
        sel = $urandom_range(0, 7);
        if (sel == 0) return 12'hFFF;
        if (sel == 1) return 12'h000;
        return 12'($urandom);
    endfunction

    assign add_out  = ref_adder(add_in);
    assign add_out4 = ref_adder(add_in4);

    adder_share_sched #(.NUM_REQ(NUM_REQ), .ID_W(ID_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
        .req_ready(req_ready), .add_in(add_in), .add_out(add_out),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_sum(rsp_sum), .op_count(op_count)
    );

    // Narrow-counter twin sharing the same stimulus so counter wrap is reachable.
    adder_share_sched #(.NUM_REQ(NUM_REQ), .ID_W(ID_W), .CNT_W(4)) dut4 (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
        .req_ready(req_ready4), .add_in(add_in4), .add_out(add_out4),
        .rsp_valid(rsp_valid4), .rsp_ready(rsp_ready), .rsp_id(rsp_id4),
        .rsp_sum(rsp_sum4), .op_count(op_count4)
    );

    // ---------------- reference model / scoreboard ----------------
    int                 mon_ptr = 0;
    bit                 mon_out = 0;
    int                 mon_age = 0;
    int                 m_count = 0;
    bit                 mon_en  = 0;
    int                 mon_gi;
    logic [NUM_REQ-1:0] mon_eg;
    bit                 mon_ev;
    int                 q_id[$];
    logic [12:0]        q_sum[$];
    bit                 hold_ok = 0;
    logic [NUM_REQ-1:0] prev_v, prev_x;
    logic [NUM_REQ*12-1:0] prev_a, prev_b;

    always @(negedge clk) begin
        if (rst) begin
            vectors++;
            if (req_ready !== '0) begin
                miscompares++;
                $display("FAIL mon_rst_ready: got %b expected 0", req_ready);
            end
            mon_ptr = 0; mon_out = 0; mon_age = 0; m_count = 0;
            q_id.delete(); q_sum.delete();
            mon_en = 1; hold_ok = 0;
        end else if (mon_en) begin
            mon_gi = -1;
            if (!mon_out || (mon_age >= 1 && rsp_ready)) begin
                for (int k = 0; k < NUM_REQ; k++) begin
                    if (mon_gi < 0 && req_valid[(mon_ptr + k) % NUM_REQ])
                        mon_gi = (mon_ptr + k) % NUM_REQ;
                end
            end
            mon_eg = '0;
            if (mon_gi >= 0) mon_eg[mon_gi] = 1'b1;
            vectors++;
            if (req_ready !== mon_eg || req_ready4 !== mon_eg) begin
                miscompares++;
                $display("FAIL mon_grant: got %b/%b expected %b", req_ready, req_ready4, mon_eg);
            end
            mon_ev = mon_out && (mon_age >= 1);
            vectors++;
            if (rsp_valid !== mon_ev || rsp_valid4 !== mon_ev) begin
                miscompares++;
                $display("FAIL mon_rsp_valid: got %b/%b expected %b", rsp_valid, rsp_valid4, mon_ev);
            end
            if (mon_ev) begin
                vectors++;
                if (q_id.size() == 0) begin
                    miscompares++;
                    $display("FAIL mon_rsp_data: got result with empty model queue");
                end else if (rsp_id !== ID_W'(q_id[0]) || rsp_sum !== q_sum[0] ||
                             rsp_id4 !== ID_W'(q_id[0]) || rsp_sum4 !== q_sum[0]) begin
                    miscompares++;
                    $display("FAIL mon_rsp_data: got id %0d sum %h expected id %0d sum %h",
                             rsp_id, rsp_sum, q_id[0], q_sum[0]);
                end
            end
            vectors++;
            if (op_count !== CNT_W'(m_count) || op_count4 !== 4'(m_count)) begin
                miscompares++;
                $display("FAIL mon_op_count: got %h/%h expected %h", op_count, op_count4, m_count);
            end
            if (hold_ok) begin
                for (int k = 0; k < NUM_REQ; k++) begin
                    if (prev_v[k] && !prev_x[k]) begin
                        vectors++;
                        if (!req_valid[k] || req_a[k*12 +: 12] !== prev_a[k*12 +: 12] ||
                            req_b[k*12 +: 12] !== prev_b[k*12 +: 12]) begin
                            miscompares++;
                            $display("FAIL req_hold: requester %0d changed before accept", k);
                        end
                    end
                end
            end
            prev_v = req_valid; prev_x = req_valid & req_ready;
            prev_a = req_a;     prev_b = req_b;  hold_ok = 1;
            if (mon_ev && rsp_ready) begin
                if (q_id.size() > 0) begin
                    void'(q_id.pop_front());
                    void'(q_sum.pop_front());
                end
                m_count++;
                mon_out = 0;
            end
            if (mon_gi >= 0) begin
                q_id.push_back(mon_gi);
                q_sum.push_back(13'(req_a[mon_gi*12 +: 12]) + 13'(req_b[mon_gi*12 +: 12]));
                mon_out = 1; mon_age = 0;
                mon_ptr = (mon_gi + 1) % NUM_REQ;
            end else if (mon_out) begin
                mon_age++;
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic v, input logic [11:0] a, input logic [11:0] b);
        req_valid[i]     = v;
        req_a[i*12 +: 12] = a;
        req_b[i*12 +: 12] = b;
    endtask

    task automatic do_reset();
        rst = 1'b1; req_valid = '0; rsp_ready = 1'b0;
        nxt(); nxt();
        rst = 1'b0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        do_reset();
        @(negedge clk);
        vectors++;
        if (add_in !== 24'h0 || rsp_valid !== 1'b0 || rsp_id !== '0 ||
            rsp_sum !== 13'h0 || op_count !== '0) begin
            miscompares++;
            $display("FAIL reset_state: got add_in %h v %b id %0d sum %h cnt %h expected all 0",
                     add_in, rsp_valid, rsp_id, rsp_sum, op_count);
        end
        nxt();
    endtask

    task automatic test_single();
        do_reset();
        rsp_ready = 1'b1;
        set_req(0, 1'b1, 12'hFFF, 12'h001);
        @(negedge clk);
        vectors++;
        if (req_ready !== 4'b0001) begin
            miscompares++; $display("FAIL single_grant: got %b expected 0001", req_ready);
        end
        nxt();
        set_req(0, 1'b0, 12'hFFF, 12'h001);
        @(negedge clk);
        vectors++;
        if (rsp_valid !== 1'b0 || add_in !== ilv(12'hFFF, 12'h001)) begin
            miscompares++;
            $display("FAIL single_calc: got v %b add_in %h expected 0 %h", rsp_valid, add_in, ilv(12'hFFF, 12'h001));
        end
        nxt();
        @(negedge clk);
        vectors++;
        if (rsp_valid !== 1'b1 || rsp_sum !== 13'h1000 || rsp_id !== 2'd0) begin
            miscompares++;
            $display("FAIL single_rsp: got v %b sum %h id %0d expected 1 1000 0", rsp_valid, rsp_sum, rsp_id);
        end
        nxt();
        @(negedge clk);
        vectors++;
        if (op_count !== 16'd1 || rsp_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL single_count: got cnt %h v %b expected 1 0", op_count, rsp_valid);
        end
        nxt();
    endtask

    task automatic test_round_robin();
        int  n, last, g;
        bit  acc;
        n = 0; last = 0; g = 0;
        do_reset();
        rsp_ready = 1'b1;
        for (int i = 0; i < NUM_REQ; i++) set_req(i, 1'b1, rnd12(), rnd12());
        for (int cyc = 0; cyc < 30 && n < 5; cyc++) begin
            @(negedge clk);
            acc = 0;
            if (req_ready != '0) begin
                for (int k = NUM_REQ - 1; k >= 0; k--) if (req_ready[k]) g = k;
                acc = 1;
                vectors++;
                if (g != n % NUM_REQ) begin
                    miscompares++; $display("FAIL rr_order: got %0d expected %0d", g, n % NUM_REQ);
                end
                if (n > 0) begin
                    vectors++;
                    if (cyc - last != 2) begin
                        miscompares++; $display("FAIL rr_spacing: got %0d cycles expected 2", cyc - last);
                    end
                end
                last = cyc;
                n++;
            end
            nxt();
            if (acc) set_req(g, 1'b1, rnd12(), rnd12());
        end
        vectors++;
        if (n != 5) begin
            miscompares++; $display("FAIL rr_timeout: got %0d grants expected 5", n);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        set_req(0, 1'b1, 12'h2A5, 12'h3C1);
        @(negedge clk);
        nxt();
        set_req(0, 1'b0, 12'h0, 12'h0);
        set_req(2, 1'b1, 12'h7FF, 12'h800);
        @(negedge clk);
        vectors++;
        if (req_ready !== '0) begin
            miscompares++; $display("FAIL bp_calc_ready: got %b expected 0000", req_ready);
        end
        nxt();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            vectors++;
            if (rsp_valid !== 1'b1 || rsp_sum !== 13'h0666 || rsp_id !== 2'd0 || req_ready !== '0) begin
                miscompares++;
                $display("FAIL bp_hold: got v %b sum %h id %0d rdy %b expected 1 0666 0 0000",
                         rsp_valid, rsp_sum, rsp_id, req_ready);
            end
            nxt();
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        vectors++;
        if (req_ready !== 4'b0100) begin
            miscompares++; $display("FAIL bp_release_grant: got %b expected 0100", req_ready);
        end
        nxt();
        set_req(2, 1'b0, 12'h0, 12'h0);
        @(negedge clk);
        vectors++;
        if (op_count !== 16'd1 || rsp_valid !== 1'b0) begin
            miscompares++; $display("FAIL bp_count: got cnt %h v %b expected 1 0", op_count, rsp_valid);
        end
        nxt();
        @(negedge clk);
        vectors++;
        if (rsp_valid !== 1'b1 || rsp_sum !== 13'h0FFF || rsp_id !== 2'd2) begin
            miscompares++;
            $display("FAIL bp_second: got v %b sum %h id %0d expected 1 0FFF 2", rsp_valid, rsp_sum, rsp_id);
        end
        nxt();
    endtask

    task automatic test_skip();
        do_reset();
        rsp_ready = 1'b1;
        set_req(1, 1'b1, 12'h001, 12'h002);
        @(negedge clk);
        nxt();
        set_req(1, 1'b0, 12'h0, 12'h0);
        nxt(); nxt();
        set_req(1, 1'b1, 12'h111, 12'h222);
        set_req(3, 1'b1, 12'h333, 12'h444);
        @(negedge clk);
        vectors++;
        if (req_ready !== 4'b1000) begin
            miscompares++; $display("FAIL skip_first: got %b expected 1000", req_ready);
        end
        nxt();
        set_req(3, 1'b0, 12'h0, 12'h0);
        nxt();
        @(negedge clk);
        vectors++;
        if (req_ready !== 4'b0010) begin
            miscompares++; $display("FAIL skip_second: got %b expected 0010", req_ready);
        end
        nxt();
        set_req(1, 1'b0, 12'h0, 12'h0);
        nxt(); nxt();
    endtask

    task automatic test_reset_calc();
        do_reset();
        rsp_ready = 1'b1;
        set_req(2, 1'b1, 12'h123, 12'h456);
        @(negedge clk);
        nxt();
        set_req(2, 1'b0, 12'h0, 12'h0);
        rst = 1'b1;
        nxt();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            vectors++;
            if (rsp_valid !== 1'b0 || rsp_sum !== 13'h0 || rsp_id !== '0 ||
                add_in !== 24'h0 || op_count !== '0) begin
                miscompares++;
                $display("FAIL rstcalc_state: got v %b sum %h id %0d add_in %h cnt %h expected all 0",
                         rsp_valid, rsp_sum, rsp_id, add_in, op_count);
            end
            nxt();
        end
        set_req(0, 1'b1, 12'h00A, 12'h00B);
        set_req(3, 1'b1, 12'h00C, 12'h00D);
        @(negedge clk);
        vectors++;
        if (req_ready !== 4'b0001) begin
            miscompares++; $display("FAIL rstcalc_ptr: got %b expected 0001", req_ready);
        end
        nxt();
    endtask

    task automatic test_extremes();
        int guard;
        do_reset();
        rsp_ready = 1'b1;
        set_req(1, 1'b1, 12'h000, 12'h000);
        @(negedge clk);
        nxt();
        set_req(1, 1'b0, 12'h0, 12'h0);
        nxt();
        @(negedge clk);
        vectors++;
        if (rsp_valid !== 1'b1 || rsp_sum !== 13'h0000) begin
            miscompares++; $display("FAIL ext_zero: got v %b sum %h expected 1 0000", rsp_valid, rsp_sum);
        end
        nxt();
        set_req(1, 1'b1, 12'hFFF, 12'hFFF);
        @(negedge clk);
        nxt();
        set_req(1, 1'b0, 12'h0, 12'h0);
        nxt();
        @(negedge clk);
        vectors++;
        if (rsp_valid !== 1'b1 || rsp_sum !== 13'h1FFE) begin
            miscompares++; $display("FAIL ext_max: got v %b sum %h expected 1 1FFE", rsp_valid, rsp_sum);
        end
        nxt();
        set_req(0, 1'b1, 12'h5A5, 12'hA5A);
        guard = 0;
        while (m_count < 16 && guard < 200) begin
            nxt();
            guard++;
        end
        @(negedge clk);
        vectors++;
        if (op_count !== 16'd16 || op_count4 !== 4'd0) begin
            miscompares++;
            $display("FAIL ext_wrap: got cnt %h cnt4 %h expected 0010 0", op_count, op_count4);
        end
        nxt();
    endtask

    task automatic test_random();
        logic [NUM_REQ-1:0] xfer;
        do_reset();
        for (int cyc = 0; cyc < 600; cyc++) begin
            @(negedge clk);
            xfer = req_valid & req_ready;
            nxt();
            rsp_ready = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < NUM_REQ; i++) begin
                if (xfer[i]) begin
                    set_req(i, $urandom_range(0, 1) == 1, rnd12(), rnd12());
                end else if (!req_valid[i] && $urandom_range(0, 2) == 0) begin
                    set_req(i, 1'b1, rnd12(), rnd12());
                end
            end
        end
        do_reset();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish expected finish before timeout");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_back_to_back();
        test_skip();
        test_reset_calc();
        test_extremes();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
